dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single data memory port between the processor core's load/store path and a DMA/loader requester.
- Core accesses are combinational-read, same-cycle, matching the single-cycle datapath; the DMA requester gets bounded bursts.
- Anti-starvation counter guarantees DMA progress; core is stalled (PC hold) only while DMA owns the port.
- Sits between the core datapath (ALU address, store-mux data, load-mux input) and the data memory.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_BURST, 8, max consecutive DMA beats per ownership (≥1)
- STARVE_LIMIT, 4, cycles DMA may wait behind active core requests before forced takeover (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- core_req  in  1  core memory access this cycle (load or store)
- core_we  in  1  core store enable
- core_addr  in  ADDR_W  core address
- core_wdata  in  DATA_W  core store data
- core_rdata  out  DATA_W  core load data
- core_stall  out  1  core must hold PC/regfile write this cycle
- dma_req  in  1  DMA access request, held until granted
- dma_we  in  1  DMA write enable
- dma_addr  in  ADDR_W  DMA address
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA beat accepted this cycle
- dma_rdata  out  DATA_W  DMA read data, valid when dma_rvalid
- dma_rvalid  out  1  DMA read beat completes this cycle
- mem_addr  out  ADDR_W  to data memory
- mem_wdata  out  DATA_W  to data memory
- mem_we  out  1  to data memory (sync write)
- mem_rdata  in  DATA_W  from data memory (combinational read)

Behaviour:
- Interface: one clock clk; reset synchronous, active-high.
- State owner ∈ {OWN_CORE, OWN_DMA}; registers wait_cnt (log2 STARVE_LIMIT+1 bits), beat_cnt (log2 MAX_BURST+1 bits).
- Reset: owner=OWN_CORE, wait_cnt=0, beat_cnt=0.
- mem_we is forced 0 while reset=1; all other outputs follow the OWN_CORE muxing.
- OWN_CORE outputs:
  - mem_* = core_*; mem_we = core_req & core_we.
  - core_rdata = mem_rdata; core_stall = 0; dma_gnt = 0; dma_rvalid = 0.
- OWN_DMA outputs:
  - mem_* = dma_*; mem_we = dma_req & dma_we.
  - dma_gnt = dma_req; dma_rvalid = dma_req & ~dma_we; dma_rdata = mem_rdata.
  - core_stall = core_req; core_rdata = mem_rdata (don't-care).
- OWN_CORE transitions:
  - dma_req & ~core_req → OWN_DMA; wait_cnt=0, beat_cnt=0.
  - dma_req & core_req: wait_cnt++. When wait_cnt==STARVE_LIMIT-1 that cycle → OWN_DMA; wait_cnt=0, beat_cnt=0.
  - ~dma_req: wait_cnt=0.
- OWN_DMA transitions:
  - Each granted beat increments beat_cnt.
  - → OWN_CORE when ~dma_req, or when a beat is granted with beat_cnt==MAX_BURST-1. On exit, beat_cnt=0.
- Latency: core zero-wait when owner=OWN_CORE. A DMA request seen in OWN_CORE is first granted the following cycle, at most STARVE_LIMIT cycles later.
- Core stall bound: MAX_BURST cycles per DMA ownership.
- Simultaneous core_req & dma_req in OWN_CORE: core is served that cycle.
- Reset mid-burst: next edge returns to OWN_CORE. The write presented during the reset cycle is suppressed.

Optional Feature:
- Macro DMEM_ARB_STATS_EN.
- Defined: adds outputs stall_cycles (32) and dma_beats (32), saturating counters cleared by reset.
  - stall_cycles increments when core_stall=1.
  - dma_beats increments when dma_gnt=1.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package dmem_arb_pkg:
  - owner_e enum {OWN_CORE=1'b0, OWN_DMA=1'b1}
  - default ADDR_W/DATA_W constants
- One natural sub-module: sat_counter (width param, inc, clear, saturating). Used for both stats counters; instanced only under DMEM_ARB_STATS_EN.

Test Plan:
- Reset, then core_req=1, core_we=1, addr=0x10, wdata=0xDEADBEEF → mem_we=1 same cycle, core_stall=0. Next cycle a load from 0x10 gives core_rdata=0xDEADBEEF.
- core_req=0, dma_req=1 held, DMA writes 0x20..0x3C with MAX_BURST=8:
  - cycle 1: no grant.
  - cycles 2–9: 8 grants.
  - cycle 10: owner=OWN_CORE, dma_gnt=0.
  - cycle 11: grants resume if still requesting.
- core_req=1 continuous and dma_req=1 with STARVE_LIMIT=4 → DMA granted on cycle 5. core_stall=1 for the burst cycles, then 0.
- DMA read of 0x10 (holds 0xDEADBEEF) → dma_gnt=1, dma_rvalid=1, dma_rdata=0xDEADBEEF in the grant cycle.
- DMA writing mid-burst (beat 3), reset asserted 1 cycle → mem_we=0 that cycle. Next cycle owner=OWN_CORE and core_stall=0.
- With DMEM_ARB_STATS_EN, 8-beat burst while core_req=1 throughout → dma_beats=8 and stall_cycles=8.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared owner type and default widths for the data memory arbiter
package dmem_arb_pkg;

    typedef enum logic {
        OWN_CORE = 1'b0,
        OWN_DMA  = 1'b1
    } owner_e;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Holds at all-ones rather than wrapping so long runs never read back as small values.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data memory port between the core and a DMA requester
// Optional stall/beat statistics counters are enabled with DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic [DATA_W-1:0] core_rdata,
    output logic              core_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [31:0]       dma_beats
`endif
);

    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam int BEAT_W = $clog2(MAX_BURST + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STARVE_LIMIT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(MAX_BURST - 1);

    owner_e            owner;
    owner_e            eff_owner;
    logic [WAIT_W-1:0] wait_cnt;
    logic [BEAT_W-1:0] beat_cnt;

    // While reset is high the port behaves as if the core owns it, so a DMA write is dropped.
    assign eff_owner  = reset ? OWN_CORE : owner;
    assign core_rdata = mem_rdata;
    assign dma_rdata  = mem_rdata;

    always_comb begin
        mem_addr   = core_addr;
        mem_wdata  = core_wdata;
        mem_we     = core_req & core_we;
        core_stall = 1'b0;
        dma_gnt    = 1'b0;
        dma_rvalid = 1'b0;
        if (eff_owner == OWN_DMA) begin
            mem_addr   = dma_addr;
            mem_wdata  = dma_wdata;
            mem_we     = dma_req & dma_we;
            core_stall = core_req;
            dma_gnt    = dma_req;
            dma_rvalid = dma_req & ~dma_we;
        end
        if (reset) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            owner    <= OWN_CORE;
            wait_cnt <= '0;
            beat_cnt <= '0;
        end else begin
            case (owner)
                OWN_CORE: begin
                    beat_cnt <= '0;
                    if (dma_req && !core_req) begin
                        owner    <= OWN_DMA;
                        wait_cnt <= '0;
                    end else if (dma_req) begin
                        // Core wins contention until DMA has waited STARVE_LIMIT cycles.
                        if (wait_cnt == WAIT_LAST) begin
                            owner    <= OWN_DMA;
                            wait_cnt <= '0;
                        end else begin
                            wait_cnt <= wait_cnt + WAIT_W'(1);
                        end
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                OWN_DMA: begin
                    wait_cnt <= '0;
                    if (!dma_req || (beat_cnt == BEAT_LAST)) begin
                        owner    <= OWN_CORE;
                        beat_cnt <= '0;
                    end else begin
                        beat_cnt <= beat_cnt + BEAT_W'(1);
                    end
                end
            endcase
        end
    end

`ifdef DMEM_ARB_STATS_EN
    sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (core_stall),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(32)) u_beat_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (dma_gnt),
        .count (dma_beats)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural data memory
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, dma_req, dma_we;
    logic [31:0] core_addr, core_wdata, dma_addr, dma_wdata;
    logic [31:0] core_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        core_stall, dma_gnt, dma_rvalid, mem_we;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stall_cycles, dma_beats;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        we;
    } beat_t;

    beat_t       sb[$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;

    dmem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_gnt    (dma_gnt),
        .dma_rdata  (dma_rdata),
        .dma_rvalid (dma_rvalid),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .dma_beats    (dma_beats)
`endif
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        core_req = 1'b0;
        core_we  = 1'b0;
        dma_req  = 1'b0;
        dma_we   = 1'b0;
        for (int i = 0; i < n; i++) next_cycle();
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h40;
        core_wdata = 32'h1234_5678;
        dma_req    = 1'b1;
        dma_we     = 1'b1;
        dma_addr   = 32'h44;
        dma_wdata  = 32'h0;
        @(negedge clk);
        total_cnt++;
        if (mem_we !== 1'b0) $display("FAIL reset_mem_we got %b want 0", mem_we); else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 32'h40) $display("FAIL reset_mem_addr got %h want 00000040", mem_addr); else pass_cnt++;
        total_cnt++;
        if (core_stall !== 1'b0 || dma_gnt !== 1'b0 || dma_rvalid !== 1'b0)
            $display("FAIL reset_ctrl got stall=%b gnt=%b rvalid=%b want 0 0 0", core_stall, dma_gnt, dma_rvalid);
        else pass_cnt++;
`ifdef DMEM_ARB_STATS_EN
        total_cnt++;
        if (stall_cycles !== 32'd0 || dma_beats !== 32'd0)
            $display("FAIL reset_stats got %0d %0d want 0 0", stall_cycles, dma_beats);
        else pass_cnt++;
`endif
        next_cycle();
        reset = 1'b0;
        idle(1);
    endtask

    task automatic test_core_access();
        core_req   = 1'b1;
        core_we    = 1'b1;
        core_addr  = 32'h10;
        core_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        total_cnt++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEAD_BEEF)
            $display("FAIL core_store got we=%b addr=%h data=%h want 1 00000010 deadbeef", mem_we, mem_addr, mem_wdata);
        else pass_cnt++;
        total_cnt++;
        if (core_stall !== 1'b0) $display("FAIL core_store_stall got %b want 0", core_stall); else pass_cnt++;
        next_cycle();
        core_we = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (core_rdata !== 32'hDEAD_BEEF) $display("FAIL core_load got %h want deadbeef", core_rdata); else pass_cnt++;
        total_cnt++;
        if (mem_we !== 1'b0) $display("FAIL core_load_we got %b want 0", mem_we); else pass_cnt++;
        idle(1);
    endtask

    task automatic test_dma_burst();
        beat_t b;
        sb.delete();
        for (int i = 0; i < 9; i++) sb.push_back('{32'h20 + 32'(i * 4), 32'hA500_0000 | 32'(i), 1'b1});
        core_req = 1'b0;
        dma_we   = 1'b1;
        for (int cyc = 1; cyc <= 11; cyc++) begin
            dma_req = (sb.size() > 0);
            if (sb.size() > 0) begin
                dma_addr  = sb[0].addr;
                dma_wdata = sb[0].data;
            end
            @(negedge clk);
            total_cnt++;
            if (dma_gnt !== (((cyc >= 2) && (cyc <= 9)) || (cyc == 11)))
                $display("FAIL burst_gnt cycle %0d got %b want %b", cyc, dma_gnt, ((cyc >= 2) && (cyc <= 9)) || (cyc == 11));
            else pass_cnt++;
            if (dma_gnt === 1'b1 && sb.size() > 0) begin
                b = sb.pop_front();
                total_cnt++;
                if (mem_addr !== b.addr || mem_wdata !== b.data || mem_we !== b.we)
                    $display("FAIL burst_beat got %h %h %b want %h %h %b", mem_addr, mem_wdata, mem_we, b.addr, b.data, b.we);
                else pass_cnt++;
            end
            next_cycle();
        end
        total_cnt++;
        if (sb.size() != 0) $display("FAIL burst_left got %0d beats pending want 0", sb.size()); else pass_cnt++;
        idle(2);
        core_req  = 1'b1;
        core_addr = 32'h3C;
        @(negedge clk);
        total_cnt++;
        if (core_rdata !== 32'hA500_0007) $display("FAIL burst_readback got %h want a5000007", core_rdata); else pass_cnt++;
        idle(1);
    endtask

    task automatic starve_run(input logic [31:0] base);
        beat_t b;
        sb.delete();
        for (int i = 0; i < 8; i++) sb.push_back('{base + 32'(i * 4), 32'hC300_0000 | 32'(i), 1'b1});
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'h10;
        dma_we    = 1'b1;
        for (int cyc = 1; cyc <= 13; cyc++) begin
            dma_req = (sb.size() > 0);
            if (sb.size() > 0) begin
                dma_addr  = sb[0].addr;
                dma_wdata = sb[0].data;
            end
            @(negedge clk);
            total_cnt++;
            if (dma_gnt !== ((cyc >= 5) && (cyc <= 12)) || core_stall !== ((cyc >= 5) && (cyc <= 12)))
                $display("FAIL starve cycle %0d got gnt=%b stall=%b want %b", cyc, dma_gnt, core_stall, (cyc >= 5) && (cyc <= 12));
            else pass_cnt++;
            if (cyc == 1) begin
                total_cnt++;
                if (core_rdata !== 32'hDEAD_BEEF) $display("FAIL starve_core_rdata got %h want deadbeef", core_rdata); else pass_cnt++;
            end
            if (dma_gnt === 1'b1 && sb.size() > 0) begin
                b = sb.pop_front();
                total_cnt++;
                if (mem_addr !== b.addr || mem_wdata !== b.data || mem_we !== b.we)
                    $display("FAIL starve_beat got %h %h %b want %h %h %b", mem_addr, mem_wdata, mem_we, b.addr, b.data, b.we);
                else pass_cnt++;
            end
            if (cyc != 13) next_cycle();
        end
    endtask

    task automatic test_starvation();
        starve_run(32'h80);
        idle(2);
    endtask

    task automatic test_dma_read();
        beat_t b;
        int    gnt_cyc = 0;
        sb.delete();
        sb.push_back('{32'h10, 32'hDEAD_BEEF, 1'b0});
        core_req = 1'b0;
        dma_we   = 1'b0;
        dma_addr = 32'h10;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            dma_req = (sb.size() > 0);
            @(negedge clk);
            if (dma_gnt === 1'b1 && sb.size() > 0) begin
                gnt_cyc = cyc;
                b = sb.pop_front();
                total_cnt++;
                if (dma_rvalid !== 1'b1 || dma_rdata !== b.data || mem_we !== 1'b0)
                    $display("FAIL dma_read got rvalid=%b data=%h we=%b want 1 %h 0", dma_rvalid, dma_rdata, mem_we, b.data);
                else pass_cnt++;
            end
            next_cycle();
        end
        total_cnt++;
        if (gnt_cyc != 2) $display("FAIL dma_read_latency got cycle %0d want 2", gnt_cyc); else pass_cnt++;
        idle(2);
    endtask

    task automatic test_reset_mid_burst();
        beat_t b;
        sb.delete();
        for (int i = 0; i < 3; i++) sb.push_back('{32'hC0 + 32'(i * 4), 32'h5A00_0000 | 32'(i), 1'b1});
        core_req = 1'b0;
        dma_req  = 1'b1;
        dma_we   = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            if (sb.size() > 0) begin
                dma_addr  = sb[0].addr;
                dma_wdata = sb[0].data;
            end
            if (cyc == 4) reset = 1'b1;
            @(negedge clk);
            if (cyc < 4) begin
                total_cnt++;
                if (dma_gnt !== (cyc >= 2)) $display("FAIL rst_burst_gnt cycle %0d got %b want %b", cyc, dma_gnt, cyc >= 2); else pass_cnt++;
                if (dma_gnt === 1'b1 && sb.size() > 0) begin
                    b = sb.pop_front();
                    total_cnt++;
                    if (mem_addr !== b.addr || mem_we !== b.we)
                        $display("FAIL rst_burst_beat got %h %b want %h %b", mem_addr, mem_we, b.addr, b.we);
                    else pass_cnt++;
                end
            end else begin
                total_cnt++;
                if (mem_we !== 1'b0 || dma_gnt !== 1'b0)
                    $display("FAIL rst_burst_suppress got we=%b gnt=%b want 0 0", mem_we, dma_gnt);
                else pass_cnt++;
            end
            next_cycle();
        end
        reset     = 1'b0;
        core_req  = 1'b1;
        core_we   = 1'b0;
        core_addr = 32'hC8;
        @(negedge clk);
        total_cnt++;
        if (core_stall !== 1'b0 || dma_gnt !== 1'b0 || core_rdata !== 32'h0)
            $display("FAIL rst_burst_after got stall=%b gnt=%b rdata=%h want 0 0 00000000", core_stall, dma_gnt, core_rdata);
        else pass_cnt++;
        next_cycle();
        dma_req   = 1'b0;
        core_addr = 32'hC4;
        @(negedge clk);
        total_cnt++;
        if (core_rdata !== 32'h5A00_0001) $display("FAIL rst_burst_beat2 got %h want 5a000001", core_rdata); else pass_cnt++;
        sb.delete();
        idle(2);
    endtask

`ifdef DMEM_ARB_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        starve_run(32'h100);
        total_cnt++;
        if (dma_beats !== 32'd8 || stall_cycles !== 32'd8)
            $display("FAIL stats got beats=%0d stalls=%0d want 8 8", dma_beats, stall_cycles);
        else pass_cnt++;
        idle(2);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout reached without finishing");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset      = 1'b1;
        core_req   = 1'b0;
        core_we    = 1'b0;
        core_addr  = 32'h0;
        core_wdata = 32'h0;
        dma_req    = 1'b0;
        dma_we     = 1'b0;
        dma_addr   = 32'h0;
        dma_wdata  = 32'h0;
        test_reset();
        test_core_access();
        test_dma_burst();
        test_starvation();
        test_dma_read();
        test_reset_mid_burst();
`ifdef DMEM_ARB_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
